// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: opcodes, command-word field positions and FSM state encodings for pulse_gen_multi
package pulse_gen_pkg;
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_PULSE     = 8'h01;
  localparam logic [7:0] OP_SET_AMP   = 8'h02;
  localparam logic [7:0] OP_SYNC      = 8'h03;
  localparam logic [7:0] OP_PULSE_ABS = 8'h04;
  localparam int CMD_HI    = 31;
  localparam int CMD_LO    = 24;
  localparam int COARSE_HI = 23;
  localparam int COARSE_LO = 8;
  localparam int FINE_HI   = 7;
  localparam int FINE_LO   = 0;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_SPILL  = 3'd4;
endpackage

// File: rtl/pulse_mask_gen.sv
// pulse_mask_gen: sample-enable mask for a PW-sample pulse starting at fine, or its spill into the next beat
// Ports: fine_i (start sample), spill_i (1 = mask of the overflow beat), mask_o (one bit per sample).
module pulse_mask_gen
  import pulse_gen_pkg::*;
#(
  parameter int SPB = 16,
  parameter int PW  = 4
) (
  input  logic [$clog2(SPB)-1:0] fine_i,
  input  logic                   spill_i,
  output logic [SPB-1:0]         mask_o
);
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < SPB; i++)
      mask_o[i] = spill_i ? (i + SPB < int'(fine_i) + PW) : (i >= int'(fine_i) && i < int'(fine_i) + PW);
  end
endmodule

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: FIFO-driven pulse scheduler emitting rectangular pulses into a continuous AXIS sample stream
// Ports: clk/rst (sync, active-high); fifo_dout/fifo_empty/fifo_rd_en (FWFT command FIFO);
//   m_axis_tdata/tvalid/tready (sample stream); busy, cmd_err (sticky), timebase (accepted-beat count).
// Optional: define PULSE_GEN_ABS_TIME_EN to add opcode 0x04 PULSE_ABS (pulse when timebase[15:0]==coarse).
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int          SAMPLES_PER_BEAT = 16,
  parameter int          SAMPLE_W         = 16,
  parameter int          PULSE_WIDTH      = 4,
  parameter logic [15:0] DEFAULT_AMP      = 16'h7FFF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [31:0]                          fifo_dout,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rd_en,
  output logic [SAMPLES_PER_BEAT*SAMPLE_W-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 busy,
  output logic                                 cmd_err,
  output logic [31:0]                          timebase
);
  localparam int LW = $clog2(SAMPLES_PER_BEAT);
  localparam int DW = SAMPLES_PER_BEAT * SAMPLE_W;
  logic [2:0] state_q, state_d;
  logic [31:0] cmd_q, cmd_d, timebase_q, timebase_d;
  logic [15:0] cnt_q, cnt_d, coarse, wait_c;
  logic [SAMPLE_W-1:0] amp_q, amp_d;
  logic [DW-1:0] tdata_q, tdata_d, pulse_beat;
  logic [SAMPLES_PER_BEAT-1:0] mask;
  logic [7:0] op;
  logic [LW-1:0] fine;
  logic tvalid_q, rd_en_q, rd_en_d, err_q, err_d, sync_q, sync_d;
  logic acc, is_pulse, is_abs, known, arm, hit, spill, unused_fine;
  assign op = cmd_q[CMD_HI:CMD_LO];
  assign coarse = cmd_q[COARSE_HI:COARSE_LO];
  assign fine = cmd_q[FINE_LO +: LW];
  assign unused_fine = ^cmd_q[FINE_HI:FINE_LO+LW];
  assign is_pulse = op == OP_PULSE;
`ifdef PULSE_GEN_ABS_TIME_EN
  assign is_abs = op == OP_PULSE_ABS;
`else
  assign is_abs = 1'b0;
`endif
  assign known = op <= OP_SYNC || is_abs;
  assign acc = tvalid_q && m_axis_tready;
  assign timebase_d = acc ? (sync_q ? 32'd0 : timebase_q + 32'd1) : timebase_q;
  // A pulse command counts down on accepted beats from DECODE onward; the beat loaded
  // at the accept where the countdown (or absolute-time match) hits is the pulse beat.
  assign arm = state_q == S_WAIT || (state_q == S_DECODE && (is_pulse || is_abs));
  assign wait_c = state_q == S_DECODE ? coarse : cnt_q;
  assign hit = is_abs ? timebase_d[15:0] == coarse : wait_c == 16'd0;
  assign spill = int'(fine) + PULSE_WIDTH > SAMPLES_PER_BEAT;
  pulse_mask_gen #(.SPB(SAMPLES_PER_BEAT), .PW(PULSE_WIDTH)) u_mask (
    .fine_i (fine),
    .spill_i(state_q == S_EMIT),
    .mask_o (mask)
  );
  for (genvar i = 0; i < SAMPLES_PER_BEAT; i++) begin : g_beat
    assign pulse_beat[i*SAMPLE_W +: SAMPLE_W] = mask[i] ? amp_q : '0;
  end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    amp_d = amp_q;
    err_d = err_q;
    sync_d = sync_q && !acc;
    rd_en_d = 1'b0;
    tdata_d = acc ? '0 : tdata_q;
    if (state_q == S_IDLE && !fifo_empty) begin
      rd_en_d = 1'b1;
      cmd_d = fifo_dout;
      state_d = S_DECODE;
    end
    if (state_q == S_DECODE) begin
      state_d = is_pulse || is_abs ? S_WAIT : S_IDLE;
      cnt_d = coarse;
      amp_d = op == OP_SET_AMP ? SAMPLE_W'(coarse) : amp_q;
      err_d = err_q || !known;
      sync_d = sync_d || op == OP_SYNC;
    end
    if (arm && acc) begin
      state_d = hit ? S_EMIT : S_WAIT;
      cnt_d = wait_c - 16'd1;
      tdata_d = hit ? pulse_beat : '0;
    end
    if (state_q == S_EMIT && acc) begin
      state_d = spill ? S_SPILL : S_IDLE;
      tdata_d = spill ? pulse_beat : '0;
    end
    if (state_q == S_SPILL && acc) state_d = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      amp_q <= SAMPLE_W'(DEFAULT_AMP);
      err_q <= 1'b0;
      sync_q <= 1'b0;
      rd_en_q <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      timebase_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      amp_q <= amp_d;
      err_q <= err_d;
      sync_q <= sync_d;
      rd_en_q <= rd_en_d;
      tdata_q <= tdata_d;
      tvalid_q <= 1'b1;
      timebase_q <= timebase_d;
    end
  end
  assign fifo_rd_en = rd_en_q;
  assign m_axis_tdata = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy = state_q != S_IDLE;
  assign cmd_err = err_q;
  assign timebase = timebase_q;
endmodule
